// File: rtl/adder64_1stage.sv
// adder64_1stage: 64-bit unsigned adder, carry-chained ADD_WIDTH-bit segments, one output register stage
module adder64_1stage #(
  parameter int ADD_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] x,
  input  logic [63:0] y,
  output logic [64:0] sum
);
  localparam int N = 64 / ADD_WIDTH;
  logic [N:0]  w_c;
  logic [63:0] w_s;
  logic [64:0] r_sum;
  if (ADD_WIDTH < 1 || 64 % ADD_WIDTH != 0) begin : g_bad_width
    $error("adder64_1stage: ADD_WIDTH=%0d does not divide 64", ADD_WIDTH);
  end
  assign w_c[0] = 1'b0;
  // carry ripples through every segment in the same cycle; boundaries are retiming points
  for (genvar k = 0; k < N; k++) begin : g_seg
    assign {w_c[k+1], w_s[k*ADD_WIDTH +: ADD_WIDTH]} =
      {1'b0, x[k*ADD_WIDTH +: ADD_WIDTH]} + {1'b0, y[k*ADD_WIDTH +: ADD_WIDTH]} + {{ADD_WIDTH{1'b0}}, w_c[k]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sum <= '0;
    else        r_sum <= {w_c[N], w_s};
  assign sum = r_sum;
endmodule

// File: tb/tb_adder64_1stage.sv
// tb_adder64_1stage: directed and random checks of adder64_1stage at ADD_WIDTH 8/16/32/64
module tb_adder64_1stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] x, y;
  logic [64:0] s8, s16, s32, s64;
  int checks = 0;
  int errors = 0;
  always #10 clk = ~clk;
  adder64_1stage #(.ADD_WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .x(x), .y(y), .sum(s8));
  adder64_1stage #(.ADD_WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .x(x), .y(y), .sum(s16));
  adder64_1stage #(.ADD_WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .x(x), .y(y), .sum(s32));
  adder64_1stage #(.ADD_WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .x(x), .y(y), .sum(s64));
  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [64:0] exp);
    chk({tag, "_w8"},  s8,  exp);
    chk({tag, "_w16"}, s16, exp);
    chk({tag, "_w32"}, s32, exp);
    chk({tag, "_w64"}, s64, exp);
  endtask
  task automatic apply(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [64:0] exp);
    x = a;
    y = b;
    @(negedge clk);
    chk_all(tag, exp);
  endtask
  logic [63:0] ra, rb;
  initial begin
    rst_n = 1'b0;
    x = '0;
    y = '0;
    @(negedge clk);
    chk_all("rst_hold", 65'd0);
    x = 64'd5;
    @(negedge clk);
    chk_all("rst_x5", 65'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      apply("ramp", 64'(k), 64'(k), 65'(2 * k));
      if (k == 10) begin
        #5 rst_n = 1'b0;
        #1 chk_all("async_clr", 65'd0);
        @(negedge clk);
        chk_all("rst_mid", 65'd0);
        rst_n = 1'b1;
      end
    end
    chk_all("ramp_last", 65'd40);
    apply("seg15", 64'h0000_0000_0000_FFFF, 64'd1, 65'h0_0000_0000_0001_0000);
    apply("seg31", 64'h0000_0000_FFFF_FFFF, 64'd1, 65'h0_0000_0001_0000_0000);
    apply("seg47", 64'h0000_FFFF_FFFF_FFFF, 64'd1, 65'h0_0001_0000_0000_0000);
    apply("seg7",  64'h0000_0000_0000_00FF, 64'd1, 65'h0_0000_0000_0000_0100);
    apply("prop",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65'h1_0000_0000_0000_0000);
    apply("max",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE);
    apply("zero",  64'd0, 64'd0, 65'd0);
    apply("mix",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 65'h1_0000_0000_0000_0001);
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      apply("rand", ra, rb, {1'b0, ra} + {1'b0, rb});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
